uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 105 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int unsigned FRAME_BITS    = 10;
    localparam int unsigned GUARD_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    always_comb begin
        logic [31:0] idx;
        idx    = '0;
        winner = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!any && req[idx]) begin
                winner = idx[IDX_W-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a single UART transmitter; holds off each
// new grant until the previous frame plus a guard interval has elapsed.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned GUARD = GUARD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                period,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_sync,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic [35:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] winner;
    logic             any;
    logic [N_REQ-1:0] ready_int;
    logic [31:0]      eff_period;
    logic [35:0]      frame_len;
    logic [31:0]      ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (winner),
        .any    (any)
    );

    // A zero period would give a zero-length frame; clamp to one clock per bit.
    assign eff_period = (period == 32'd0) ? 32'd1 : period;
    assign frame_len  = 36'(eff_period) * 36'(FRAME_BITS) + 36'(GUARD);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        ready_int = '0;
        ptr_next  = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    ready_int = N_REQ'(1) << winner;
                    data_d    = req_data[{winner, 3'b000} +: 8];
                    grant_d   = winner;
                    ptr_next  = 32'(winner) + 32'd1;
                    rr_ptr_d  = (ptr_next == N_REQ) ? '0 : ptr_next[IDX_W-1:0];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // Period is sampled here only, so later changes leave this frame alone.
                cnt_d   = frame_len;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 36'd1;
                if (cnt_q <= 36'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= 8'h00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready = rst ? '0 : ready_int;
    assign tx_sync   = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign tx_data   = data_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants, a
// monitor checks accept pulses, grant spacing and the following tx_sync.
module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] period = 32'd4;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    logic [3:0]  req_ready;
    logic        tx_sync;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    uart_tx_arbiter #(
        .N_REQ (N_REQ),
        .GUARD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .period    (period),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_sync   (tx_sync),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    initial begin
        exp_t       e;
        logic       pend;
        logic [7:0] pd;
        logic [1:0] pid;
        logic [3:0] exp_rdy;
        int         last;
        pend = 1'b0;
        pd   = '0;
        pid  = '0;
        last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    checks++;
                    if (tx_sync !== 1'b1 || tx_data !== pd || grant_id !== pid) begin
                        errors++;
                        $display("FAIL sync: tx_sync=%b tx_data=%h grant_id=%0d, want 1 %h %0d",
                                 tx_sync, tx_data, grant_id, pd, pid);
                    end
                    pend = 1'b0;
                end else if (tx_sync) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_sync: tx_sync=1 at cycle %0d, want 0", cyc);
                end
                if (req_ready != 4'b0000) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_accept: req_ready=%b, want 0000", req_ready);
                    end else begin
                        e       = q.pop_front();
                        exp_rdy = 4'b0001 << e.id;
                        if (req_ready !== exp_rdy) begin
                            errors++;
                            $display("FAIL grant: req_ready=%b, want %b", req_ready, exp_rdy);
                        end
                        if (e.gap != 0) begin
                            checks++;
                            if (cyc - last != e.gap) begin
                                errors++;
                                $display("FAIL gap: spacing=%0d, want %0d", cyc - last, e.gap);
                            end
                        end
                        pend = 1'b1;
                        pd   = e.data;
                        pid  = 2'(e.id);
                    end
                    last = cyc;
                end
            end
        end
    end

    task automatic push(input int id, input int gap);
        exp_t e;
        e.id   = id;
        e.data = 8'h10 + 8'(id);
        e.gap  = gap;
        q.push_back(e);
    endtask

    // Waits for n accept pulses, then returns just after the accepting edge.
    task automatic wait_accepts(input int n);
        int seen = 0;
        int t    = 0;
        while (seen < n && t < 5000) begin
            @(negedge clk);
            t++;
            if (req_ready != 4'b0000) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL timeout: accepts=%0d, want %0d", seen, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_tx_sync", 32'(tx_sync), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        int bcnt;

        // Reset state, with requests pending
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        req_valid = 4'b0000;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request at period 4: F = 44, busy for 45 clocks
        period = 32'd4;
        req_data[7:0] = 8'hA5;
        begin
            exp_t e;
            e.id = 0; e.data = 8'hA5; e.gap = 0;
            q.push_back(e);
        end
        req_valid = 4'b0001;
        wait_accepts(1);
        req_valid = 4'b0000;
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
        end
        check("busy_len", 32'(bcnt), 32'd45);
        req_data[7:0] = 8'h10;
        wait_idle();

        // Fairness at period 2 from a fresh pointer: 0,1,2,3,0 spaced 26
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        period = 32'd2;
        push(0, 0); push(1, 26); push(2, 26); push(3, 26); push(0, 26);
        req_valid = 4'b1111;
        wait_accepts(5);
        req_valid = 4'b0000;
        wait_idle();

        // Pointer wrap: grant 3, then 1001 -> 0 then 3
        push(3, 0); push(0, 26); push(3, 26);
        req_valid = 4'b1000;
        wait_accepts(1);
        req_valid = 4'b1001;
        wait_accepts(2);
        req_valid = 4'b0000;
        wait_idle();

        // Requester 1 withdraws before its grant; requester 2 takes the slot
        push(0, 0); push(2, 26);
        req_valid = 4'b0001;
        wait_accepts(1);
        req_valid = 4'b0010;
        repeat (5) @(posedge clk);
        #1 req_valid = 4'b0100;
        wait_accepts(1);
        req_valid = 4'b0000;
        wait_idle();

        // period 0 behaves as 1: F = 14, accepts every 16 clocks (ptr at 3)
        period = 32'd0;
        push(3, 0); push(0, 16); push(1, 16);
        req_valid = 4'b1111;
        wait_accepts(3);
        req_valid = 4'b0000;
        wait_idle();

        // Period change in WAIT leaves the current frame at 26
        period = 32'd2;
        push(0, 0); push(0, 26); push(0, 1006);
        req_valid = 4'b0001;
        wait_accepts(1);
        @(posedge clk);
        #1 period = 32'd100;
        wait_accepts(2);
        req_valid = 4'b0000;
        wait_idle();

        // Reset 5 clocks into WAIT, then 0100 from rr_ptr 0 -> grant 2
        period = 32'd4;
        push(0, 0);
        req_valid = 4'b0001;
        wait_accepts(1);
        req_valid = 4'b0000;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push(2, 0);
        req_valid = 4'b0100;
        wait_accepts(1);
        req_valid = 4'b0000;
        wait_idle();
        repeat (3) @(posedge clk);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
